axi_aw_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one slave's AW/W channel pair among NUM masters inside the AXI4 crossbar. It issues a registered one-hot grant, which drives the per-master masking in front of the crossbar's OR-reduction merge trees. The grant is held from the AW request through the last W beat of that burst, then rotates fairly. It also gates the merged W path and flags bursts that exceed the AXI4 beat limit.

---
 rtl/axi_aw_rr_arbiter.sv | 151 +++++++++++++++
 tb/tb_axi_aw_rr_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/axi_aw_rr_arbiter.sv
// Round-robin AW/W arbiter for one crossbar slave port: one-hot grant held from
// the AW request through the last W beat, W gating and an overlength-burst flag.
module axi_aw_rr_arbiter #(
  parameter int NUM       = 2,
  parameter int IDX_W     = (NUM > 1 ? $clog2(NUM) : 1),
  parameter int MAX_BEATS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM-1:0]   aw_valid_i,
  output logic [NUM-1:0]   aw_ready_o,
  input  logic             slv_aw_ready_i,
  input  logic             w_valid_i,
  input  logic             slv_w_ready_i,
  input  logic             w_last_i,
  output logic [NUM-1:0]   grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             w_gate_o,
  output logic             burst_err_o
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [NUM-1:0]     grant, grant_next;
  logic [IDX_W-1:0]   grant_idx, grant_idx_next;
  logic [IDX_W-1:0]   ptr, ptr_next;
  logic [CNT_W-1:0]   beats, beats_next;
  logic               w_gate, w_gate_next;
  logic               err, err_next;
  logic [IDX_W-1:0]   sel_lo, sel_hi, sel;
  logic               any_lo, any_hi;
  logic               aw_hs, w_hs;

  // Rotating priority: the lowest requester at or above ptr wins, else the lowest overall.
  always_comb begin
    sel_lo = '0;
    sel_hi = '0;
    any_lo = 1'b0;
    any_hi = 1'b0;
    for (int c = NUM - 1; c >= 0; c--) begin
      if (aw_valid_i[c]) begin
        sel_lo = IDX_W'(c);
        any_lo = 1'b1;
        if (IDX_W'(c) >= ptr) begin
          sel_hi = IDX_W'(c);
          any_hi = 1'b1;
        end
      end
    end
  end

  assign sel   = any_hi ? sel_hi : sel_lo;
  assign aw_hs = (state == ADDR) && ((aw_valid_i & grant) != '0) && slv_aw_ready_i;
  assign w_hs  = (state == DATA) && w_valid_i && slv_w_ready_i;

  // Next-state and next-output logic for the grant FSM.
  always_comb begin
    state_next     = state;
    grant_next     = grant;
    grant_idx_next = grant_idx;
    ptr_next       = ptr;
    beats_next     = beats;
    w_gate_next    = w_gate;
    err_next       = err;
    case (state)
      IDLE: begin
        if (any_lo) begin
          state_next     = ADDR;
          grant_next     = NUM'(1) << sel;
          grant_idx_next = sel;
        end else begin
          grant_next     = '0;
          grant_idx_next = '0;
        end
      end
      ADDR: begin
        if (aw_hs) begin
          state_next  = DATA;
          w_gate_next = 1'b1;
          beats_next  = '0;
        end else begin
          state_next  = ADDR;
        end
      end
      DATA: begin
        if (w_hs) begin
          if (beats != CNT_W'(MAX_BEATS)) begin
            beats_next = beats + CNT_W'(1);
          end else begin
            beats_next = beats;
          end
          if (w_last_i) begin
            state_next     = IDLE;
            grant_next     = '0;
            grant_idx_next = '0;
            w_gate_next    = 1'b0;
            // Winner moves to the back of the rotation.
            ptr_next       = (grant_idx == IDX_W'(NUM - 1)) ? '0 : grant_idx + IDX_W'(1);
          end else if (beats == CNT_W'(MAX_BEATS - 1)) begin
            err_next = 1'b1;
          end else begin
            err_next = err;
          end
        end else begin
          state_next = DATA;
        end
      end
      default: begin
        state_next     = IDLE;
        grant_next     = '0;
        grant_idx_next = '0;
        w_gate_next    = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any burst without rotating.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      ptr       <= '0;
      beats     <= '0;
      w_gate    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      grant     <= grant_next;
      grant_idx <= grant_idx_next;
      ptr       <= ptr_next;
      beats     <= beats_next;
      w_gate    <= w_gate_next;
      err       <= err_next;
    end
  end

  assign aw_ready_o  = ((state == ADDR) && slv_aw_ready_i) ? grant : '0;
  assign grant_o     = grant;
  assign grant_idx_o = grant_idx;
  assign w_gate_o    = w_gate;
  assign burst_err_o = err;

endmodule

// File: tb/tb_axi_aw_rr_arbiter.sv
// Directed bench: vector table on a 2-master instance, hand-written sequences
// (fairness, backpressure, W stall, overlength) on a 4-master MAX_BEATS=4 instance.
module tb_axi_aw_rr_arbiter;

  logic clk;
  int   n_tests;
  int   n_fail;

  // 2-master instance
  logic       rst2, awr2, wv2, wr2, wl2;
  logic [1:0] av2, ar2, g2;
  logic       idx2, gate2, err2;

  // 4-master instance, short beat limit
  logic       rst4, awr4, wv4, wr4, wl4;
  logic [3:0] av4, ar4, g4;
  logic [1:0] idx4;
  logic       gate4, err4;

  axi_aw_rr_arbiter #(.NUM(2), .MAX_BEATS(256)) u_dut2 (
    .clk(clk), .rst(rst2), .aw_valid_i(av2), .aw_ready_o(ar2),
    .slv_aw_ready_i(awr2), .w_valid_i(wv2), .slv_w_ready_i(wr2), .w_last_i(wl2),
    .grant_o(g2), .grant_idx_o(idx2), .w_gate_o(gate2), .burst_err_o(err2)
  );

  axi_aw_rr_arbiter #(.NUM(4), .MAX_BEATS(4)) u_dut4 (
    .clk(clk), .rst(rst4), .aw_valid_i(av4), .aw_ready_o(ar4),
    .slv_aw_ready_i(awr4), .w_valid_i(wv4), .slv_w_ready_i(wr4), .w_last_i(wl4),
    .grant_o(g4), .grant_idx_o(idx4), .w_gate_o(gate4), .burst_err_o(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] av;
    logic       awr;
    logic       wv;
    logic       wr;
    logic       wl;
    logic [1:0] e_awrdy;
    logic [1:0] e_grant;
    logic       e_idx;
    logic       e_gate;
    logic       e_err;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset4();
    rst4 = 1'b1;
    step();
    step();
    rst4 = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst2 = 1'b1; av2 = 2'b00; awr2 = 1'b0; wv2 = 1'b0; wr2 = 1'b0; wl2 = 1'b0;
    rst4 = 1'b1; av4 = 4'b0000; awr4 = 1'b0; wv4 = 1'b0; wr4 = 1'b0; wl4 = 1'b0;

    //          rst   av     awr   wv    wr    wl    awrdy  grant  idx   gate  err
    vecs[0]  = '{1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};

    step();

    for (int i = 0; i < 14; i++) begin
      rst2 = vecs[i].rst;  av2 = vecs[i].av;  awr2 = vecs[i].awr;
      wv2  = vecs[i].wv;   wr2 = vecs[i].wr;  wl2  = vecs[i].wl;
      #1;
      chk($sformatf("row%0d aw_ready", i), 32'(ar2), 32'(vecs[i].e_awrdy));
      step();
      chk($sformatf("row%0d grant", i), 32'(g2), 32'(vecs[i].e_grant));
      chk($sformatf("row%0d grant_idx", i), 32'(idx2), 32'(vecs[i].e_idx));
      chk($sformatf("row%0d w_gate", i), 32'(gate2), 32'(vecs[i].e_gate));
      chk($sformatf("row%0d burst_err", i), 32'(err2), 32'(vecs[i].e_err));
    end
    rst2 = 1'b1;

    // Fairness: four masters, continuous requests, 1-beat bursts.
    av4 = 4'b1111; awr4 = 1'b1; wv4 = 1'b1; wr4 = 1'b1; wl4 = 1'b1;
    reset4();
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("fair%0d idx", k), 32'(idx4), 32'(k % 4));
      chk($sformatf("fair%0d grant", k), 32'(g4), 32'(1) << (k % 4));
      step();
      chk($sformatf("fair%0d gate", k), 32'(gate4), 32'(1));
      step();
      chk($sformatf("fair%0d bubble", k), 32'(g4), 32'(0));
    end

    // Backpressure on AW with a competing requester.
    av4 = 4'b0011; awr4 = 1'b0; wv4 = 1'b0; wr4 = 1'b0; wl4 = 1'b0;
    reset4();
    step();
    chk("bp grant0", 32'(g4), 32'(4'b0001));
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d aw_ready", k), 32'(ar4), 32'(0));
      step();
      chk($sformatf("bp%0d grant", k), 32'(g4), 32'(4'b0001));
      chk($sformatf("bp%0d gate", k), 32'(gate4), 32'(0));
    end
    awr4 = 1'b1;
    #1;
    chk("bp aw_ready", 32'(ar4), 32'(4'b0001));
    step();
    chk("bp data gate", 32'(gate4), 32'(1));
    chk("bp data grant", 32'(g4), 32'(4'b0001));

    // W stall: ready pattern 1,0,0,1, WLAST on the second accepted beat.
    av4 = 4'b0010; awr4 = 1'b0; wv4 = 1'b1;
    wr4 = 1'b1; wl4 = 1'b0;
    step();
    chk("stall beat1 grant", 32'(g4), 32'(4'b0001));
    wr4 = 1'b0; wl4 = 1'b1;
    step();
    chk("stall wait1 grant", 32'(g4), 32'(4'b0001));
    step();
    chk("stall wait2 gate", 32'(gate4), 32'(1));
    wr4 = 1'b1;
    step();
    chk("stall release grant", 32'(g4), 32'(0));
    chk("stall release gate", 32'(gate4), 32'(0));
    wv4 = 1'b0; wl4 = 1'b0;
    step();
    chk("stall next idx", 32'(idx4), 32'(1));
    chk("stall next grant", 32'(g4), 32'(4'b0010));

    // Overlength: 6 beats against a 4-beat limit; W seen outside DATA is ignored.
    av4 = 4'b0100; awr4 = 1'b1; wv4 = 1'b1; wr4 = 1'b1; wl4 = 1'b0;
    reset4();
    chk("ovl reset err", 32'(err4), 32'(0));
    step();
    chk("ovl grant", 32'(g4), 32'(4'b0100));
    chk("ovl idx", 32'(idx4), 32'(2));
    step();
    chk("ovl addr err", 32'(err4), 32'(0));
    av4 = 4'b0000; awr4 = 1'b0;
    for (int b = 1; b <= 6; b++) begin
      wl4 = (b == 6);
      step();
      chk($sformatf("ovl beat%0d err", b), 32'(err4), 32'(b >= 4));
      chk($sformatf("ovl beat%0d grant", b), 32'(g4), (b == 6) ? 32'(0) : 32'(4'b0100));
    end
    wv4 = 1'b0; wl4 = 1'b0;
    step();
    step();
    chk("ovl sticky err", 32'(err4), 32'(1));
    reset4();
    chk("ovl cleared err", 32'(err4), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
